// File: rtl/dragonfang_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dragonfang_pkg
//  Description : Shared types for the vector conversion sequencer: conversion
//                kind, sequencer state encoding, decoded execution control
//                and group-extent helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dragonfang_pkg;

  localparam int unsigned DF_VLEN            = 64;
  localparam int unsigned DF_VREG_ADDR_WIDTH = 5;

  // Decoded conversion control forwarded to the conversion unit.
  typedef struct packed {
    logic [3:0] funct;
    logic [1:0] sew;
    logic [2:0] rm;
    logic       is_signed;
  } execution_vector_t;

  typedef enum logic [1:0] {
    CVT_SINGLE = 2'd0,
    CVT_WIDEN  = 2'd1,
    CVT_NARROW = 2'd2
  } cvt_kind_t;

  typedef enum logic [2:0] {
    SEQ_IDLE       = 3'd0,
    SEQ_READ       = 3'd1,
    SEQ_CONVERT    = 3'd2,
    SEQ_WRITE      = 3'd3,
    SEQ_WRITE_HIGH = 3'd4,
    SEQ_DONE       = 3'd5
  } cvt_seq_state_t;

  // Register group size G = 1 << lmul (1, 2, 4 or 8).
  function automatic logic [4:0] group_size(input logic [1:0] lmul);
    return 5'd1 << lmul;
  endfunction

  // Number of source registers touched: narrowing consumes two per result.
  function automatic logic [4:0] src_extent(input cvt_kind_t kind, input logic [1:0] lmul);
    return (kind == CVT_NARROW) ? (group_size(lmul) << 1) : group_size(lmul);
  endfunction

  // Number of destination registers touched: widening produces two per source.
  function automatic logic [4:0] dst_extent(input cvt_kind_t kind, input logic [1:0] lmul);
    return (kind == CVT_WIDEN) ? (group_size(lmul) << 1) : group_size(lmul);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_conversion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_conversion_sequencer
//  Description : Steps one conversion instruction across its LMUL register
//                group: reads each source register, presents it to the shared
//                conversion unit and writes the results back to the VRF
//                (single-width, widening or narrowing).
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_conversion_sequencer
  import dragonfang_pkg::*;
#(
  parameter int unsigned VLEN            = DF_VLEN,
  parameter int unsigned VREG_ADDR_WIDTH = DF_VREG_ADDR_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  execution_vector_t          issue_vector,
  input  cvt_kind_t                  issue_kind,
  input  logic [1:0]                 issue_lmul,
  input  logic [VREG_ADDR_WIDTH-1:0] issue_vs2,
  input  logic [VREG_ADDR_WIDTH-1:0] issue_vd,
  output logic [VREG_ADDR_WIDTH-1:0] vrf_read_address,
  input  logic [VLEN-1:0]            vrf_read_data,
  output logic                       vrf_write_enable,
  output logic [VREG_ADDR_WIDTH-1:0] vrf_write_address,
  output logic [VLEN-1:0]            vrf_write_data,
  output execution_vector_t          cvt_execution_vector,
  output logic [VLEN-1:0]            cvt_vs2,
  input  logic [VLEN-1:0]            cvt_vd,
  input  logic [VLEN-1:0]            cvt_vd_high,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned c_half = VLEN / 2;
  localparam int unsigned c_ext_width = VREG_ADDR_WIDTH + 2;
  localparam logic [c_ext_width-1:0] c_num_vregs = c_ext_width'(2 ** VREG_ADDR_WIDTH);

  cvt_seq_state_t               r_state;
  cvt_seq_state_t               w_state_next;

  execution_vector_t            r_vec;
  cvt_kind_t                    r_kind;
  logic [1:0]                   r_lmul;
  logic [VREG_ADDR_WIDTH-1:0]   r_vs2;
  logic [VREG_ADDR_WIDTH-1:0]   r_vd;
  logic [2:0]                   r_idx;
  logic                         r_half;
  logic                         r_err;
  logic [VLEN-1:0]              r_vs2_q;
  logic [c_half-1:0]            r_pack_q;

  logic                         w_accept;
  logic                         w_advance;
  logic                         w_range_err;
  logic                         w_last;
  logic                         w_narrow;
  logic                         w_widen;
  logic [c_ext_width-1:0]       w_src_end;
  logic [c_ext_width-1:0]       w_dst_end;
  logic [2:0]                   w_last_idx;
  logic [VREG_ADDR_WIDTH-1:0]   w_read_addr;
  logic [VREG_ADDR_WIDTH-1:0]   w_write_addr;
  logic [VREG_ADDR_WIDTH-1:0]   w_write_high_addr;

  // Group bounds of the offered instruction; either group running past the
  // last register makes the whole instruction fail without touching the VRF.
  assign w_src_end   = c_ext_width'(issue_vs2) + c_ext_width'(src_extent(issue_kind, issue_lmul));
  assign w_dst_end   = c_ext_width'(issue_vd)  + c_ext_width'(dst_extent(issue_kind, issue_lmul));
  assign w_range_err = (w_src_end > c_num_vregs) || (w_dst_end > c_num_vregs);

  assign w_narrow   = (r_kind == CVT_NARROW);
  assign w_widen    = (r_kind == CVT_WIDEN);
  assign w_last_idx = 3'(group_size(r_lmul) - 5'd1);
  assign w_last     = (r_idx == w_last_idx);

  // Narrowing walks the source group two registers per index: vs2 + 2i + h.
  assign w_read_addr = w_narrow ? (r_vs2 + VREG_ADDR_WIDTH'({r_idx, r_half}))
                                : (r_vs2 + VREG_ADDR_WIDTH'(r_idx));

  // Widening writes the low result to vd + 2i and the high one to vd + 2i + 1.
  assign w_write_addr      = w_widen ? (r_vd + VREG_ADDR_WIDTH'({r_idx, 1'b0}))
                                     : (r_vd + VREG_ADDR_WIDTH'(r_idx));
  assign w_write_high_addr = r_vd + VREG_ADDR_WIDTH'({r_idx, 1'b1});

  // The conversion unit always sees the most recently captured source register.
  assign cvt_vs2 = r_vs2_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and all control/VRF outputs derived from the current state.
  always_comb begin
    w_state_next         = r_state;
    w_accept             = 1'b0;
    w_advance            = 1'b0;
    issue_ready          = 1'b0;
    busy                 = 1'b0;
    done                 = 1'b0;
    error                = 1'b0;
    vrf_read_address     = '0;
    vrf_write_enable     = 1'b0;
    vrf_write_address    = '0;
    vrf_write_data       = '0;
    cvt_execution_vector = '0;

    case (r_state)
      SEQ_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          w_accept     = 1'b1;
          w_state_next = w_range_err ? SEQ_DONE : SEQ_READ;
        end
      end

      SEQ_READ: begin
        busy                 = 1'b1;
        cvt_execution_vector = r_vec;
        vrf_read_address     = w_read_addr;
        w_state_next         = SEQ_CONVERT;
      end

      SEQ_CONVERT: begin
        busy                 = 1'b1;
        cvt_execution_vector = r_vec;
        // First half of a narrowing pair: fetch the partner register next.
        w_state_next         = (w_narrow && !r_half) ? SEQ_READ : SEQ_WRITE;
      end

      SEQ_WRITE: begin
        busy                 = 1'b1;
        cvt_execution_vector = r_vec;
        vrf_write_enable     = 1'b1;
        vrf_write_address    = w_write_addr;
        vrf_write_data       = w_narrow ? {cvt_vd[c_half-1:0], r_pack_q} : cvt_vd;
        if (w_widen) begin
          w_state_next = SEQ_WRITE_HIGH;
        end else if (w_last) begin
          w_state_next = SEQ_DONE;
        end else begin
          w_advance    = 1'b1;
          w_state_next = SEQ_READ;
        end
      end

      SEQ_WRITE_HIGH: begin
        busy                 = 1'b1;
        cvt_execution_vector = r_vec;
        vrf_write_enable     = 1'b1;
        vrf_write_address    = w_write_high_addr;
        vrf_write_data       = cvt_vd_high;
        if (w_last) begin
          w_state_next = SEQ_DONE;
        end else begin
          w_advance    = 1'b1;
          w_state_next = SEQ_READ;
        end
      end

      SEQ_DONE: begin
        done         = 1'b1;
        error        = r_err;
        w_state_next = SEQ_IDLE;
      end

      default: begin
        w_state_next = SEQ_IDLE;
      end
    endcase
  end

  // Instruction latches, loop index/half flag and the source/pack datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vec    <= '0;
      r_kind   <= CVT_SINGLE;
      r_lmul   <= 2'd0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_idx    <= 3'd0;
      r_half   <= 1'b0;
      r_err    <= 1'b0;
      r_vs2_q  <= '0;
      r_pack_q <= '0;
    end else begin
      if (w_accept) begin
        r_vec  <= issue_vector;
        r_kind <= issue_kind;
        r_lmul <= issue_lmul;
        r_vs2  <= issue_vs2;
        r_vd   <= issue_vd;
        r_idx  <= 3'd0;
        r_half <= 1'b0;
        r_err  <= w_range_err;
      end

      case (r_state)
        SEQ_READ: begin
          // vs2_q still holds the even source of the pair here, so the unit
          // output is its narrowed result; keep the low half for packing.
          if (w_narrow && r_half) begin
            r_pack_q <= cvt_vd[c_half-1:0];
          end
        end
        SEQ_CONVERT: begin
          r_vs2_q <= vrf_read_data;
          if (w_narrow && !r_half) begin
            r_half <= 1'b1;
          end
        end
        SEQ_WRITE, SEQ_WRITE_HIGH: begin
          if (w_advance) begin
            r_idx  <= r_idx + 3'd1;
            r_half <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_conversion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_conversion_sequencer
//  Description : Self-checking bench for vector_conversion_sequencer with a
//                VRF model, a stand-in conversion unit and a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_conversion_sequencer;
  import dragonfang_pkg::*;

  localparam int VLEN = 64;
  localparam int AW   = 5;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  execution_vector_t issue_vector = '0;
  cvt_kind_t         issue_kind = CVT_SINGLE;
  logic [1:0]        issue_lmul = 2'd0;
  logic [AW-1:0]     issue_vs2 = '0;
  logic [AW-1:0]     issue_vd = '0;
  logic [AW-1:0]     vrf_read_address;
  logic [VLEN-1:0]   vrf_read_data = '0;
  logic              vrf_write_enable;
  logic [AW-1:0]     vrf_write_address;
  logic [VLEN-1:0]   vrf_write_data;
  execution_vector_t cvt_execution_vector;
  logic [VLEN-1:0]   cvt_vs2;
  logic [VLEN-1:0]   cvt_vd;
  logic [VLEN-1:0]   cvt_vd_high;
  logic              busy;
  logic              done;
  logic              error;

  vector_conversion_sequencer #(.VLEN(VLEN), .VREG_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vector(issue_vector), .issue_kind(issue_kind), .issue_lmul(issue_lmul),
    .issue_vs2(issue_vs2), .issue_vd(issue_vd),
    .vrf_read_address(vrf_read_address), .vrf_read_data(vrf_read_data),
    .vrf_write_enable(vrf_write_enable), .vrf_write_address(vrf_write_address),
    .vrf_write_data(vrf_write_data),
    .cvt_execution_vector(cvt_execution_vector), .cvt_vs2(cvt_vs2),
    .cvt_vd(cvt_vd), .cvt_vd_high(cvt_vd_high),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Stand-in conversion unit: arbitrary but control-dependent transforms.
  function automatic logic [63:0] unit_lo(input logic [63:0] x, input logic [9:0] v);
    return {x[31:0], x[63:32]} ^ {54'd0, v} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction
  function automatic logic [63:0] unit_hi(input logic [63:0] x, input logic [9:0] v);
    return x + 64'h0123_4567_89AB_CDEF + {54'd0, v};
  endfunction

  logic [9:0] cvt_vec_bits;
  assign cvt_vec_bits = cvt_execution_vector;
  assign cvt_vd       = unit_lo(cvt_vs2, cvt_vec_bits);
  assign cvt_vd_high  = unit_hi(cvt_vs2, cvt_vec_bits);

  // VRF model: read data one cycle after the address, write on the edge.
  logic [63:0] vrf [32];
  always @(posedge clock) begin
    vrf_read_data <= vrf[vrf_read_address];
    if (vrf_write_enable) vrf[vrf_write_address] = vrf_write_data;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int nwrites = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Write monitor and scoreboard; also guards issue_ready against busy.
  always @(negedge clock) begin
    if (busy) check("ready_while_busy", {63'd0, issue_ready}, 64'd0);
    if (vrf_write_enable) begin
      nwrites++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {59'd0, vrf_write_address}, 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {59'd0, vrf_write_address}, {59'd0, e.addr});
        check("write_data", vrf_write_data, e.data);
      end
    end
  end

  typedef struct {
    cvt_kind_t     kind;
    logic [1:0]    lmul;
    logic [AW-1:0] vs2;
    logic [AW-1:0] vd;
    int            lat;
    logic          err;
  } vec_t;
  vec_t tbl[9];

  task automatic fill_vrf();
    for (int r = 0; r < 32; r++) vrf[r] = {$urandom, $urandom};
  endtask

  task automatic push_expected(input cvt_kind_t k, input logic [1:0] lmul,
                               input logic [AW-1:0] vs2, input logic [AW-1:0] vd,
                               input logic [9:0] v);
    int g;
    logic [63:0] lo0, lo1;
    g = 1 << lmul;
    for (int i = 0; i < g; i++) begin
      case (k)
        CVT_WIDEN: begin
          exp_q.push_back('{AW'(int'(vd) + 2*i),     unit_lo(vrf[int'(vs2) + i], v)});
          exp_q.push_back('{AW'(int'(vd) + 2*i + 1), unit_hi(vrf[int'(vs2) + i], v)});
        end
        CVT_NARROW: begin
          lo0 = unit_lo(vrf[int'(vs2) + 2*i], v);
          lo1 = unit_lo(vrf[int'(vs2) + 2*i + 1], v);
          exp_q.push_back('{AW'(int'(vd) + i), {lo1[31:0], lo0[31:0]}});
        end
        default: exp_q.push_back('{AW'(int'(vd) + i), unit_lo(vrf[int'(vs2) + i], v)});
      endcase
    end
  endtask

  // Offer an instruction at a negedge and return just after the accepting edge.
  task automatic do_issue(input cvt_kind_t k, input logic [1:0] lmul,
                          input logic [AW-1:0] vs2, input logic [AW-1:0] vd,
                          input logic [9:0] v, input bit drop_valid);
    bit ok;
    issue_kind   = k;
    issue_lmul   = lmul;
    issue_vs2    = vs2;
    issue_vd     = vd;
    issue_vector = v;
    issue_valid  = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (issue_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    if (drop_valid) issue_valid = 1'b0;
  endtask

  // Cycle number (1 = cycle after accept) of the first done pulse, 0 on timeout.
  task automatic wait_done(output int lat, output logic err);
    lat = 0;
    err = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clock);
      if (done) begin lat = t; err = error; break; end
    end
    if (lat == 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    logic err;
    logic [9:0] v;
    int expn;
    logic [63:0] e10, old11;
    int d1, d2, t;

    tbl[0] = '{CVT_SINGLE, 2'd0, 5'd4,  5'd8,  4,  1'b0};
    tbl[1] = '{CVT_WIDEN,  2'd1, 5'd2,  5'd10, 9,  1'b0};
    tbl[2] = '{CVT_NARROW, 2'd0, 5'd6,  5'd1,  6,  1'b0};
    tbl[3] = '{CVT_WIDEN,  2'd3, 5'd0,  5'd20, 1,  1'b1};
    tbl[4] = '{CVT_SINGLE, 2'd3, 5'd24, 5'd0,  25, 1'b0};
    tbl[5] = '{CVT_NARROW, 2'd1, 5'd16, 5'd28, 11, 1'b0};
    tbl[6] = '{CVT_NARROW, 2'd2, 5'd26, 5'd0,  1,  1'b1};
    tbl[7] = '{CVT_SINGLE, 2'd2, 5'd0,  5'd29, 1,  1'b1};
    tbl[8] = '{CVT_WIDEN,  2'd2, 5'd0,  5'd24, 17, 1'b0};

    fill_vrf();
    repeat (2) @(negedge clock);
    check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    check("rst_busy",        {63'd0, busy}, 64'd0);
    check("rst_done",        {63'd0, done}, 64'd0);
    check("rst_error",       {63'd0, error}, 64'd0);
    check("rst_we",          {63'd0, vrf_write_enable}, 64'd0);
    check("rst_raddr",       {59'd0, vrf_read_address}, 64'd0);
    check("rst_cvt_vs2",     cvt_vs2, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int c = 0; c < 9; c++) begin
      fill_vrf();
      v = 10'($urandom);
      nwrites = 0;
      expn = 0;
      if (!tbl[c].err) begin
        push_expected(tbl[c].kind, tbl[c].lmul, tbl[c].vs2, tbl[c].vd, v);
        expn = exp_q.size();
      end
      do_issue(tbl[c].kind, tbl[c].lmul, tbl[c].vs2, tbl[c].vd, v, 1'b1);
      wait_done(lat, err);
      check($sformatf("latency_%0d", c), 64'(lat), 64'(tbl[c].lat));
      check($sformatf("error_%0d", c), {63'd0, err}, {63'd0, tbl[c].err});
      check($sformatf("nwrites_%0d", c), 64'(nwrites), 64'(expn));
      check($sformatf("queue_left_%0d", c), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clock);
    end

    // Reset asserted during the first WRITE_HIGH of a widening op.
    fill_vrf();
    v = 10'($urandom);
    e10   = unit_lo(vrf[2], v);
    old11 = vrf[11];
    push_expected(CVT_WIDEN, 2'd1, 5'd2, 5'd10, v);
    do_issue(CVT_WIDEN, 2'd1, 5'd2, 5'd10, v, 1'b1);
    t = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (vrf_write_enable && vrf_write_address == 5'd11) begin t = 1; break; end
    end
    check("reach_write_high", 64'(t), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_we",    {63'd0, vrf_write_enable}, 64'd0);
    check("rst_mid_busy",  {63'd0, busy}, 64'd0);
    check("rst_mid_ready", {63'd0, issue_ready}, 64'd1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    check("partial_vrf10", vrf[10], e10);
    check("aborted_vrf11", vrf[11], old11);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", {63'd0, issue_ready}, 64'd1);
    check("post_rst_busy",  {63'd0, busy}, 64'd0);

    // issue_valid held high across two single-width ops.
    fill_vrf();
    v = 10'($urandom);
    push_expected(CVT_SINGLE, 2'd0, 5'd4, 5'd8, v);
    push_expected(CVT_SINGLE, 2'd0, 5'd4, 5'd8, v);
    nwrites = 0;
    do_issue(CVT_SINGLE, 2'd0, 5'd4, 5'd8, v, 1'b0);
    d1 = 0;
    d2 = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (done) begin
        if (d1 == 0) d1 = n; else if (d2 == 0) d2 = n;
      end
      if (d2 != 0) begin issue_valid = 1'b0; break; end
    end
    issue_valid = 1'b0;
    check("b2b_done1", 64'(d1), 64'd4);
    check("b2b_done2", 64'(d2), 64'd9);
    check("b2b_nwrites", 64'(nwrites), 64'd2);
    check("b2b_queue_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clock);
    check("b2b_idle_busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
